// File: rtl/btn_pkg.sv
// btn_pkg: key FSM states, default parameters and counter-width helper for button_conditioner.
package btn_pkg;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HELD} key_state_t;

    localparam int DEF_NUM_KEYS        = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_key_channel.sv
// key_channel: synchroniser, debouncer, press/release strobes and per-key FSM for one key.
// Auto-repeat (DELAY/REPEAT states and repeat counter) is built only when BTN_AUTOREPEAT_EN is defined.
module key_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [DW-1:0] db_cnt;
    logic          differ, accept, press_evt, release_evt, press_nxt;
    key_state_t    state, state_nxt;

    // Illegal parameter sets leave this marker block in the elaborated hierarchy.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    end

    // The stable state is ~key_level, so the active-low sample differs when it equals key_level.
    assign differ      = sync[1] == key_level;
    assign accept      = differ && db_cnt == DB_LAST;
    assign press_evt   = accept && !key_level;
    assign release_evt = accept && key_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync        <= 2'b11;
            db_cnt      <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            state       <= IDLE;
        end else begin
            sync        <= {sync[0], key_n};
            db_cnt      <= (!differ || accept) ? '0 : db_cnt + 1'b1;
            key_level   <= key_level ^ accept;
            key_press   <= press_nxt;
            key_release <= release_evt;
            state       <= state_nxt;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = cnt_width(RMAX - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] R_SAT   = '1;

    logic [RW-1:0] rep_cnt, rep_cnt_nxt;
    logic          rep_hit;

    always_ff @(posedge clk) begin
        if (rst) rep_cnt <= '0;
        else     rep_cnt <= rep_cnt_nxt;
    end

    // A release always wins over a repeat that falls due on the same cycle.
    always_comb begin
        state_nxt   = state;
        rep_hit     = 1'b0;
        rep_cnt_nxt = '0;
        if (release_evt) begin
            state_nxt = IDLE;
        end else if (state == IDLE) begin
            state_nxt = press_evt ? DELAY : IDLE;
        end else begin
            rep_hit     = rep_cnt == ((state == DELAY) ? RD_LAST : RP_LAST);
            state_nxt   = rep_hit ? REPEAT : state;
            rep_cnt_nxt = rep_hit ? '0 : ((rep_cnt == R_SAT) ? rep_cnt : rep_cnt + 1'b1);
        end
        press_nxt = press_evt || rep_hit;
    end
`else
    always_comb begin
        state_nxt = state;
        if (release_evt)    state_nxt = IDLE;
        else if (press_evt) state_nxt = HELD;
        press_nxt = press_evt;
    end
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced press/release strobes for NUM_KEYS active-low push-buttons.
// Define BTN_AUTOREPEAT_EN to add auto-repeat strobes on key_press.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_KEYS        = DEF_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .key_n      (key_n[k]),
            .key_level  (key_level[k]),
            .key_press  (key_press[k]),
            .key_release(key_release[k])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed table-driven checks of debounce, strobes, repeat and reset behaviour.
module tb_button_conditioner;

`ifdef BTN_AUTOREPEAT_EN
    localparam int A = 1;
`else
    localparam int A = 0;
`endif
    localparam logic AR = A[0];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key_n = 2'b11;
    logic [1:0] key_level, key_press, key_release;

    int cyc = 0;
    int pcnt [2];
    int rcnt0 = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        bit         rs;
        int         c;
        logic [1:0] kn, lvl, prs, rls;
        int         p0, p1, r0;
    } vec_t;

    vec_t tbl[$];

    button_conditioner #(
        .NUM_KEYS       (2),
        .DEBOUNCE_CYCLES(8),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) pcnt[i] += int'(key_press[i]);
        rcnt0 += int'(key_release[0]);
    endtask

    task automatic start();
        rst = 1'b1;
        key_n = 2'b11;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        pcnt[0] = 0;
        pcnt[1] = 0;
        rcnt0 = 0;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input bit rs, input int c, input logic [1:0] kn, input logic [1:0] lvl,
                       input logic [1:0] prs, input logic [1:0] rls, input int p0, input int p1, input int r0);
        vec_t v;
        v = '{rs, c, kn, lvl, prs, rls, p0, p1, r0};
        tbl.push_back(v);
    endtask

    initial begin
        pcnt[0] = 0;
        pcnt[1] = 0;
        // Clean press held ~100 cycles, then release at cycle 100 (due repeat at 110 is suppressed).
        add(1,   0, 2'b10, 2'b00, 2'b00,     2'b00, 0,        0, 0);
        add(0,   9, 2'b10, 2'b00, 2'b00,     2'b00, 0,        0, 0);
        add(0,  10, 2'b10, 2'b01, 2'b01,     2'b00, 1,        0, 0);
        add(0,  11, 2'b10, 2'b01, 2'b00,     2'b00, 1,        0, 0);
        add(0,  29, 2'b10, 2'b01, 2'b00,     2'b00, 1,        0, 0);
        add(0,  30, 2'b10, 2'b01, {1'b0,AR}, 2'b00, 1+A,      0, 0);
        add(0,  31, 2'b10, 2'b01, 2'b00,     2'b00, 1+A,      0, 0);
        add(0,  35, 2'b10, 2'b01, {1'b0,AR}, 2'b00, 1+2*A,    0, 0);
        add(0, 100, 2'b11, 2'b01, {1'b0,AR}, 2'b00, 1+15*A,   0, 0);
        add(0, 105, 2'b11, 2'b01, {1'b0,AR}, 2'b00, 1+16*A,   0, 0);
        add(0, 109, 2'b11, 2'b01, 2'b00,     2'b00, 1+16*A,   0, 0);
        add(0, 110, 2'b11, 2'b00, 2'b00,     2'b01, 1+16*A,   0, 1);
        add(0, 111, 2'b11, 2'b00, 2'b00,     2'b00, 1+16*A,   0, 1);
        add(0, 125, 2'b11, 2'b00, 2'b00,     2'b00, 1+16*A,   0, 1);
        // Bounce: toggle every 3 cycles, final low edge at cycle 30.
        add(1,   0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        for (int t = 3; t <= 30; t += 3)
            add(0, t, (t % 6 == 0) ? 2'b10 : 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(0,  39, 2'b10, 2'b00, 2'b00,     2'b00, 0,   0, 0);
        add(0,  40, 2'b10, 2'b01, 2'b01,     2'b00, 1,   0, 0);
        add(0,  41, 2'b10, 2'b01, 2'b00,     2'b00, 1,   0, 0);
        add(0,  59, 2'b10, 2'b01, 2'b00,     2'b00, 1,   0, 0);
        add(0,  60, 2'b10, 2'b01, {1'b0,AR}, 2'b00, 1+A, 0, 0);
        // Glitch: 7-cycle pulse rejected, 8-cycle pulse accepted then released.
        add(1,   0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(0,   7, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(0,  10, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(0,  20, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(0,  28, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(0,  29, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(0,  30, 2'b11, 2'b01, 2'b01, 2'b00, 1, 0, 0);
        add(0,  31, 2'b11, 2'b01, 2'b00, 2'b00, 1, 0, 0);
        add(0,  37, 2'b11, 2'b01, 2'b00, 2'b00, 1, 0, 0);
        add(0,  38, 2'b11, 2'b00, 2'b00, 2'b01, 1, 0, 1);
        add(0,  39, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1);
        add(0,  55, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1);
        // Independence: key 1 pressed 4 cycles after key 0.
        add(1,   0, 2'b10, 2'b00, 2'b00,     2'b00, 0,   0,   0);
        add(0,   4, 2'b00, 2'b00, 2'b00,     2'b00, 0,   0,   0);
        add(0,   9, 2'b00, 2'b00, 2'b00,     2'b00, 0,   0,   0);
        add(0,  10, 2'b00, 2'b01, 2'b01,     2'b00, 1,   0,   0);
        add(0,  13, 2'b00, 2'b01, 2'b00,     2'b00, 1,   0,   0);
        add(0,  14, 2'b00, 2'b11, 2'b10,     2'b00, 1,   1,   0);
        add(0,  15, 2'b00, 2'b11, 2'b00,     2'b00, 1,   1,   0);
        add(0,  30, 2'b00, 2'b11, {1'b0,AR}, 2'b00, 1+A, 1,   0);
        add(0,  34, 2'b00, 2'b11, {AR,1'b0}, 2'b00, 1+A, 1+A, 0);
        // Release accepted in DELAY exactly when the first repeat would fall due.
        add(1,   0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        add(0,  10, 2'b10, 2'b01, 2'b01, 2'b00, 1, 0, 0);
        add(0,  20, 2'b11, 2'b01, 2'b00, 2'b00, 1, 0, 0);
        add(0,  29, 2'b11, 2'b01, 2'b00, 2'b00, 1, 0, 0);
        add(0,  30, 2'b11, 2'b00, 2'b00, 2'b01, 1, 0, 1);
        add(0,  50, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 1);

        foreach (tbl[i]) begin
            if (tbl[i].rs) start();
            while (cyc < tbl[i].c) step();
            check($sformatf("vec%0d@%0d outs", i, cyc), 32'({key_level, key_press, key_release}),
                  32'({tbl[i].lvl, tbl[i].prs, tbl[i].rls}));
            check($sformatf("vec%0d@%0d counts", i, cyc), 32'({8'(pcnt[0]), 8'(pcnt[1]), 8'(rcnt0)}),
                  32'({8'(tbl[i].p0), 8'(tbl[i].p1), 8'(tbl[i].r0)}));
            key_n = tbl[i].kn;
        end

        // Reset pulse while key 0 is held mid-repeat.
        start();
        key_n = 2'b10;
        while (cyc < 30) step();
        check("pre_rst_press", 32'(key_press), 32'({1'b0, AR}));
        while (cyc < 32) step();
        rst = 1'b1;
        step();
        check("rst_clears_outs", 32'({key_level, key_press, key_release}), 32'h0);
        rst = 1'b0;
        while (cyc < 42) step();
        check("post_rst_wait", 32'({key_level, key_press}), 32'h0);
        step();
        check("post_rst_press", 32'({key_level, key_press}), 32'b0101);
        while (cyc < 62) step();
        check("post_rst_no_early_rep", 32'(key_press), 32'h0);
        step();
        check("post_rst_repeat", 32'(key_press), 32'({1'b0, AR}));
        check("post_rst_count", 32'(pcnt[0]), 32'(2 + 2 * A));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
